// File: rtl/fetcher_pkg.sv
// fetcher_pkg: shared bus types, opcodes, prediction flags and the static branch predictor.
package fetcher_pkg;
  typedef logic [31:0] inst_bus_t;
  typedef logic [31:0] addr_bus_t;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic JUMP = 1'b1;
  localparam logic NOT_JUMP = 1'b0;
  localparam int QUEUE_DEPTH_DEF = 4;
  typedef struct packed {
    inst_bus_t inst;
    addr_bus_t pc;
    logic      pd;
  } entry_t;
  typedef struct packed {
    logic      pd;
    addr_bus_t next;
  } pred_t;
  // Backward branches and JAL are predicted taken; JALR cannot be resolved here.
  function automatic pred_t predict(input inst_bus_t inst, input addr_bus_t pc);
    addr_bus_t j_imm;
    addr_bus_t b_imm;
    logic is_jal;
    logic is_bwd;
    j_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    b_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    is_jal = inst[6:0] == OP_JAL;
    is_bwd = inst[6:0] == OP_BRANCH && inst[31];
    predict.pd = is_jal || is_bwd ? JUMP : NOT_JUMP;
    predict.next = is_jal ? pc + j_imm : is_bwd ? pc + b_imm : pc + 32'd4;
  endfunction
endpackage

// File: rtl/fetcher_queue.sv
// fetch_queue: circular instruction queue with occupancy count and synchronous flush.
module fetch_queue
  import fetcher_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  entry_t                 data_i,
  output entry_t                 head_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    wr_d = clr_i ? '0 : push_i ? wr_q + AW'(1) : wr_q;
    rd_d = clr_i ? '0 : pop_i ? rd_q + AW'(1) : rd_q;
    count_d = clr_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wr_q] <= data_i;
  end
  assign head_o = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/fetcher.sv
// fetcher: instruction fetch FSM with static prediction feeding a decoder through fetch_queue.
module fetcher
  import fetcher_pkg::*;
#(
  parameter int        QUEUE_DEPTH = QUEUE_DEPTH_DEF,
  parameter addr_bus_t RESET_PC    = 32'h0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  output logic      oMC_en,
  output addr_bus_t oMC_addr,
  input  logic      iMC_done,
  input  inst_bus_t iMC_data,
  output logic      oDEC_en,
  output inst_bus_t oDEC_inst,
  output addr_bus_t oDEC_pc,
  output logic      oDEC_pd,
  input  logic      iDEC_full,
  input  logic      iROB_clr,
  input  addr_bus_t iROB_pc
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;
  logic [1:0] state_q, state_d;
  addr_bus_t pc_q, pc_d, mc_addr_q, mc_addr_d;
  logic mc_en_q, mc_en_d, dec_en_q;
  entry_t dec_q, head;
  logic [CW-1:0] count;
  logic clr, push, issue;
  pred_t pred;
  assign clr = rdy && iROB_clr;
  assign push = rdy && !iROB_clr && state_q == S_BUSY && iMC_done;
  assign issue = rdy && !iROB_clr && !iDEC_full && |count;
  assign pred = predict(iMC_data, pc_q);
  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk    (clk),
    .rst_n  (rst),
    .clr_i  (clr),
    .push_i (push),
    .pop_i  (issue),
    .data_i ('{inst: iMC_data, pc: pc_q, pd: pred.pd}),
    .head_o (head),
    .count_o(count)
  );
  // A flushed in-flight read still has to be drained, so DISCARD keeps the old request up.
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    mc_en_d = mc_en_q;
    mc_addr_d = mc_addr_q;
    if (rdy) begin
      case (state_q)
        S_IDLE: begin
          if (!iROB_clr && count != FULL) begin
            state_d = S_BUSY;
            mc_en_d = 1'b1;
            mc_addr_d = pc_q;
          end
        end
        S_BUSY: begin
          if (iMC_done) begin
            state_d = S_IDLE;
            mc_en_d = 1'b0;
            pc_d = pred.pd ? pred.next : pc_q + 32'd4;
          end else if (iROB_clr) begin
            state_d = S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (iMC_done) begin
            state_d = S_IDLE;
            mc_en_d = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
          mc_en_d = 1'b0;
        end
      endcase
      if (iROB_clr) pc_d = iROB_pc;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q <= RESET_PC;
      mc_en_q <= 1'b0;
      mc_addr_q <= '0;
      dec_en_q <= 1'b0;
      dec_q <= '{inst: '0, pc: '0, pd: NOT_JUMP};
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      mc_en_q <= mc_en_d;
      mc_addr_q <= mc_addr_d;
      dec_en_q <= issue;
      if (issue) dec_q <= head;
    end
  end
  assign oMC_en = mc_en_q;
  assign oMC_addr = mc_addr_q;
  assign oDEC_en = dec_en_q;
  assign oDEC_inst = dec_q.inst;
  assign oDEC_pc = dec_q.pc;
  assign oDEC_pd = dec_q.pd;
endmodule

// File: tb/tb_fetcher.sv
// tb_fetcher: directed self-checking bench for fetcher with a hand-driven memory responder.
module tb_fetcher;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] ADDI1 = 32'h0010_0093;
  localparam logic [31:0] ADDI2 = 32'h0020_0113;
  localparam logic [31:0] ADDI3 = 32'h0030_0193;
  localparam logic [31:0] JAL20 = 32'h0200_006F;
  localparam logic [31:0] BEQM8 = 32'hFE00_0CE3;
  logic clk = 1'b0, rst = 1'b0, rdy = 1'b1;
  logic iMC_done = 1'b0, iDEC_full = 1'b0, iROB_clr = 1'b0;
  logic [31:0] iMC_data = '0, iROB_pc = '0;
  logic oMC_en, oDEC_en, oDEC_pd;
  logic [31:0] oMC_addr, oDEC_inst, oDEC_pc;
  logic [31:0] log_pc[$], log_inst[$];
  logic log_pd[$];
  int n_assert = 0, n_fail = 0;
  fetcher #(.QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .oMC_en(oMC_en), .oMC_addr(oMC_addr), .iMC_done(iMC_done), .iMC_data(iMC_data),
    .oDEC_en(oDEC_en), .oDEC_inst(oDEC_inst), .oDEC_pc(oDEC_pc), .oDEC_pd(oDEC_pd),
    .iDEC_full(iDEC_full), .iROB_clr(iROB_clr), .iROB_pc(iROB_pc)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst && oDEC_en) begin
      log_pc.push_back(oDEC_pc);
      log_inst.push_back(oDEC_inst);
      log_pd.push_back(oDEC_pd);
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic clear_log;
    log_pc.delete();
    log_inst.delete();
    log_pd.delete();
  endtask
  task automatic chk_log(input int i, input logic [31:0] pc, input logic [31:0] inst, input logic pd);
    chk($sformatf("log%0d_pc", i), log_pc[i], pc);
    chk($sformatf("log%0d_inst", i), log_inst[i], inst);
    chk($sformatf("log%0d_pd", i), 32'(log_pd[i]), 32'(pd));
  endtask
  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_mc_en"}, 32'(oMC_en), 0);
    chk({tag, "_mc_addr"}, oMC_addr, 0);
    chk({tag, "_dec_en"}, 32'(oDEC_en), 0);
    chk({tag, "_dec_inst"}, oDEC_inst, 0);
    chk({tag, "_dec_pc"}, oDEC_pc, 0);
    chk({tag, "_dec_pd"}, 32'(oDEC_pd), 0);
  endtask
  task automatic wait_req(input logic [31:0] a);
    int n = 0;
    while (oMC_en !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk("req_en", 32'(oMC_en), 1);
    chk("req_addr", oMC_addr, a);
  endtask
  task automatic serve(input logic [31:0] a, input logic [31:0] d);
    wait_req(a);
    tick;
    iMC_done = 1'b1;
    iMC_data = d;
    tick;
    iMC_done = 1'b0;
  endtask
  initial begin
    repeat (2) tick;
    chk_outputs_zero("reset");
    rst = 1'b1;
    serve(32'h0, ADDI1);
    serve(32'h4, ADDI2);
    serve(32'h8, ADDI3);
    repeat (2) tick;
    chk("t1_count", log_pc.size(), 3);
    chk_log(0, 32'h0, ADDI1, 1'b0);
    chk_log(1, 32'h4, ADDI2, 1'b0);
    chk_log(2, 32'h8, ADDI3, 1'b0);
    clear_log;
    serve(32'hC, NOP);
    serve(32'h10, JAL20);
    serve(32'h30, BEQM8);
    serve(32'h28, NOP);
    repeat (2) tick;
    chk("t2_count", log_pc.size(), 4);
    chk_log(0, 32'hC, NOP, 1'b0);
    chk_log(1, 32'h10, JAL20, 1'b1);
    chk_log(2, 32'h30, BEQM8, 1'b1);
    chk_log(3, 32'h28, NOP, 1'b0);
    clear_log;
    iDEC_full = 1'b1;
    serve(32'h2C, NOP);
    serve(32'h30, NOP);
    serve(32'h34, NOP);
    serve(32'h38, NOP);
    for (int k = 0; k < 10; k++) begin
      tick;
      chk("full_mc_en", 32'(oMC_en), 0);
      chk("full_dec_en", 32'(oDEC_en), 0);
    end
    chk("full_log", log_pc.size(), 0);
    iDEC_full = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("drain_en", 32'(oDEC_en), 1);
      chk("drain_pc", oDEC_pc, 32'h2C + 32'(4 * k));
    end
    tick;
    chk("drain_done", 32'(oDEC_en), 0);
    serve(32'h3C, NOP);
    wait_req(32'h40);
    tick;
    iROB_clr = 1'b1;
    iROB_pc = 32'h100;
    tick;
    iROB_clr = 1'b0;
    chk("disc_en", 32'(oMC_en), 1);
    chk("disc_addr", oMC_addr, 32'h40);
    chk("disc_dec_en", 32'(oDEC_en), 0);
    clear_log;
    tick;
    iMC_done = 1'b1;
    iMC_data = ADDI1;
    tick;
    iMC_done = 1'b0;
    chk("disc_drop_en", 32'(oMC_en), 0);
    serve(32'h100, NOP);
    repeat (2) tick;
    chk("redir_count", log_pc.size(), 1);
    chk_log(0, 32'h100, NOP, 1'b0);
    iDEC_full = 1'b1;
    serve(32'h104, NOP);
    wait_req(32'h108);
    tick;
    clear_log;
    iDEC_full = 1'b0;
    iMC_done = 1'b1;
    iMC_data = NOP;
    iROB_clr = 1'b1;
    iROB_pc = 32'h200;
    tick;
    iMC_done = 1'b0;
    iROB_clr = 1'b0;
    chk("coinc_dec_en", 32'(oDEC_en), 0);
    chk("coinc_mc_en", 32'(oMC_en), 0);
    tick;
    chk("coinc_empty", 32'(oDEC_en), 0);
    chk("coinc_req_en", 32'(oMC_en), 1);
    chk("coinc_req_addr", oMC_addr, 32'h200);
    chk("coinc_log", log_pc.size(), 0);
    serve(32'h200, ADDI2);
    repeat (2) tick;
    chk("coinc_issue", log_pc.size(), 1);
    chk_log(0, 32'h200, ADDI2, 1'b0);
    wait_req(32'h204);
    tick;
    rst = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    repeat (2) tick;
    rst = 1'b1;
    chk("rel_idle", 32'(oMC_en), 0);
    tick;
    chk("rel_en", 32'(oMC_en), 1);
    chk("rel_addr", oMC_addr, 32'h0);
    clear_log;
    rdy = 1'b0;
    iMC_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("frz_en", 32'(oMC_en), 1);
      chk("frz_addr", oMC_addr, 32'h0);
    end
    rdy = 1'b1;
    serve(32'h0, ADDI3);
    repeat (2) tick;
    chk("post_count", log_pc.size(), 1);
    chk_log(0, 32'h0, ADDI3, 1'b0);
    wait_req(32'h4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
